// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - eight-phase instruction sequencer for the 8-bit accumulator CPU
// Each instruction walks the same fetch phases, then opcode-specific execute phases.
module cpu_controller #(
  parameter int OPC_W   = 3,
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  output logic [PHASE_W-1:0] phase,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               data_e,
  output logic               wr,
  output logic               halt,
  output logic               instr_end
);

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
  localparam logic [OPC_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OP_AND = 3'b011;
  localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPC_W-1:0] OP_LDA = 3'b101;
  localparam logic [OPC_W-1:0] OP_STO = 3'b110;
  localparam logic [OPC_W-1:0] OP_JMP = 3'b111;

  phase_t state_q;
  phase_t state_d;
  logic   halted_q;
  logic   halted_d;

  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;
  logic alu_op;
  logic advance;

  assign is_hlt  = (opcode == OP_HLT);
  assign is_skz  = (opcode == OP_SKZ);
  assign is_sto  = (opcode == OP_STO);
  assign is_jmp  = (opcode == OP_JMP);
  assign alu_op  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
  assign advance = enable && !halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    sel       = 1'b0;
    rd        = 1'b0;
    ld_ir     = 1'b0;
    inc_pc    = 1'b0;
    ld_pc     = 1'b0;
    ld_ac     = 1'b0;
    data_e    = 1'b0;
    wr        = 1'b0;

    if (advance) begin
      state_d = phase_t'(PHASE_W'(state_q) + PHASE_W'(1));
      if (state_q == OP_ADDR && is_hlt) begin
        halted_d = 1'b1;
      end
    end

    // Once halted, the datapath is frozen: only the halt indication remains.
    if (!halted_q) begin
      case (state_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = is_jmp;
          data_e = is_sto;
          wr     = is_sto;
        end
        default: begin
          sel = 1'b1;
        end
      endcase
    end
  end

  assign phase     = state_q;
  assign halt      = halted_q || (state_q == OP_ADDR && is_hlt);
  assign instr_end = (state_q == STORE) && enable && !halted_q;

endmodule
